// File: rtl/flag_unit_pkg.sv
// Shared definitions for the condition-code path: branch condition codes,
// flag bit positions inside the {V,N,Z} vector, reset default and the ALU
// write-mask decode.
package flag_unit_pkg;

  // Branch condition codes (3-bit field of the branch instruction)
  localparam logic [2:0] COND_NEQ  = 3'b000;
  localparam logic [2:0] COND_EQ   = 3'b001;
  localparam logic [2:0] COND_GT   = 3'b010;
  localparam logic [2:0] COND_LT   = 3'b011;
  localparam logic [2:0] COND_GTE  = 3'b100;
  localparam logic [2:0] COND_LTE  = 3'b101;
  localparam logic [2:0] COND_OVFL = 3'b110;
  localparam logic [2:0] COND_UNC  = 3'b111;

  // Bit positions inside the packed {V,N,Z} flag vector
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Default architectural flag value out of reset
  localparam logic [2:0] RST_FLAGS_DEF = 3'b000;

  // ADD and SUB (ctrl 000x) are the only ALU ops whose V and N results are
  // meaningful; every other op only produces a valid Z.
  function automatic logic is_arith(input logic [3:0] ctrl);
    return (ctrl[3:2] == 2'b00) && (ctrl[1] == 1'b0);
  endfunction

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Purely combinational branch-condition evaluator. Kept as its own module so
// the decode-stage hazard logic can reuse the exact same decode.
module branch_cond_eval
  import flag_unit_pkg::*;
(
  output logic       taken,
  input  logic [2:0] cond,
  input  logic       v,
  input  logic       n,
  input  logic       z
);

  // Map the condition code onto the supplied flags
  always_comb begin
    // NOTE: a default assignment before the case keeps every path driven,
    // so no latch can be inferred even if the case is later edited.
    taken = 1'b0;
    case (cond)
      COND_NEQ:  taken = ~z;
      COND_EQ:   taken = z;
      COND_GT:   taken = ~z & ~n;
      COND_LT:   taken = n;
      COND_GTE:  taken = z | ~n;
      COND_LTE:  taken = n | z;
      COND_OVFL: taken = v;
      COND_UNC:  taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-code consumer between EX and the PC-select path. Holds the
// architectural V/N/Z flags, writes them under a per-opcode mask, resolves
// branches against the bypassed (next-edge) flags and registers the result
// as a one-cycle br_done pulse with br_taken.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int         COND_W    = 3,
  parameter logic [2:0] RST_FLAGS = RST_FLAGS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_set_flags,
  input  logic [3:0]        ex_alu_ctrl,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  input  logic              stall,
  input  logic              flush,
  output logic              flag_v,
  output logic              flag_n,
  output logic              flag_z,
  output logic              br_done,
  output logic              br_taken
);

  logic [2:0] flags_q, flags_d;
  logic       br_done_q, br_done_d;
  logic       br_taken_q, br_taken_d;
  logic       wr;
  logic       taken_byp;

  // A flag write needs a real flag-setting instruction that is neither
  // frozen by a stall nor squashed by a flush.
  assign wr = ex_valid & ex_set_flags & ~stall & ~flush;

  // Masked next-state of the flags; this is also the bypass value
  always_comb begin
    flags_d = flags_q;
    if (wr) begin
      flags_d[FLAG_Z] = alu_z;
      if (is_arith(ex_alu_ctrl)) begin
        flags_d[FLAG_V] = alu_v;
        flags_d[FLAG_N] = alu_n;
      end
    end
  end

  // Evaluate the branch against the flags as they will be after this edge,
  // so a branch right behind a flag-setter needs no bubble.
  branch_cond_eval u_cond_eval (
    .taken (taken_byp),
    .cond  (br_cond[2:0]),
    .v     (flags_d[FLAG_V]),
    .n     (flags_d[FLAG_N]),
    .z     (flags_d[FLAG_Z])
  );

  // Branch result capture: flush kills it, stall freezes it
  always_comb begin
    br_done_d  = br_done_q;
    br_taken_d = br_taken_q;
    if (flush) begin
      br_done_d = 1'b0;
    end else if (!stall) begin
      br_done_d  = br_valid;
      br_taken_d = br_valid & taken_byp;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= RST_FLAGS;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      flags_q    <= flags_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign flag_v   = flags_q[FLAG_V];
  assign flag_n   = flags_q[FLAG_N];
  assign flag_z   = flags_q[FLAG_Z];
  assign br_done  = br_done_q;
  assign br_taken = br_taken_q;

endmodule
